// File: rtl/burst_ram_responder.sv
// Burst-RAM command responder backed by byte-lane block RAM of 64-bit words.
// Mimics the PSRAM controller timing: init delay, fixed-latency reads, masked write bursts, recovery.
module burst_ram_responder #(
    parameter int DepthBitWidth       = 10,
    parameter int BurstDataCount      = 4,
    parameter int ReadLatencyCycles   = 8,
    parameter int WriteRecoveryCycles = 4,
    parameter int InitCycles          = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        init_calib,
    input  logic        cmd,
    input  logic        cmd_en,
    input  logic [20:0] addr,
    input  logic [63:0] wr_data,
    input  logic [7:0]  data_mask,
    output logic [63:0] rd_data,
    output logic        rd_data_valid,
    output logic        busy,
    output logic        protocol_error
);

    localparam int Depth    = 1 << DepthBitWidth;
    localparam int MaxIr    = (InitCycles > ReadLatencyCycles) ? InitCycles : ReadLatencyCycles;
    localparam int MaxBw    = (BurstDataCount > WriteRecoveryCycles) ? BurstDataCount : WriteRecoveryCycles;
    localparam int MaxCount = (MaxIr > MaxBw) ? MaxIr : MaxBw;
    localparam int CntW     = $clog2(MaxCount + 1);

    localparam logic [CntW-1:0]          CntOne = 1;
    localparam logic [DepthBitWidth-1:0] PtrOne = 1;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WRITE,
        S_READ_WAIT,
        S_READ_BURST,
        S_RECOVER
    } state_t;

    state_t                   state_reg, state_next;
    logic [CntW-1:0]          cnt_reg, cnt_next;
    logic [DepthBitWidth-1:0] ptr_reg, ptr_next;
    logic                     init_calib_reg;
    logic                     protocol_error_reg;
    logic                     rd_data_valid_reg;
    logic                     wen, ren, mem_we;
    logic [DepthBitWidth-1:0] mem_addr;
    logic [DepthBitWidth-1:0] cmd_idx;

    assign cmd_idx = addr[DepthBitWidth+2:3];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= S_INIT;
            cnt_reg            <= '0;
            ptr_reg            <= '0;
            init_calib_reg     <= 1'b0;
            protocol_error_reg <= 1'b0;
            rd_data_valid_reg  <= 1'b0;
        end else begin
            state_reg         <= state_next;
            cnt_reg           <= cnt_next;
            ptr_reg           <= ptr_next;
            rd_data_valid_reg <= ren;
            if (state_next == S_IDLE)
                init_calib_reg <= 1'b1;
            if (cmd_en && state_reg != S_IDLE)
                protocol_error_reg <= 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ptr_next   = ptr_reg;
        wen        = 1'b0;
        ren        = 1'b0;
        mem_addr   = ptr_reg;
        case (state_reg)
            S_INIT: begin
                if (cnt_reg == CntW'(InitCycles - 1)) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CntOne;
                end
            end
            S_IDLE: begin
                if (cmd_en) begin
                    cnt_next = '0;
                    if (cmd) begin
                        // Beat 0 of a write lands on the command cycle itself.
                        wen      = 1'b1;
                        mem_addr = cmd_idx;
                        ptr_next = cmd_idx + PtrOne;
                        if (BurstDataCount > 1) begin
                            state_next = S_WRITE;
                            cnt_next   = CntOne;
                        end else if (WriteRecoveryCycles > 0) begin
                            state_next = S_RECOVER;
                        end
                    end else begin
                        ptr_next   = cmd_idx;
                        state_next = S_READ_WAIT;
                    end
                end
            end
            S_WRITE: begin
                wen      = 1'b1;
                ptr_next = ptr_reg + PtrOne;
                if (cnt_reg == CntW'(BurstDataCount - 1)) begin
                    cnt_next   = '0;
                    state_next = (WriteRecoveryCycles > 0) ? S_RECOVER : S_IDLE;
                end else begin
                    cnt_next = cnt_reg + CntOne;
                end
            end
            S_READ_WAIT: begin
                // RAM output is registered, so beat 0 is fetched one cycle early.
                if (cnt_reg == CntW'(ReadLatencyCycles - 2)) begin
                    ren        = 1'b1;
                    ptr_next   = ptr_reg + PtrOne;
                    cnt_next   = '0;
                    state_next = S_READ_BURST;
                end else begin
                    cnt_next = cnt_reg + CntOne;
                end
            end
            S_READ_BURST: begin
                if (cnt_reg == CntW'(BurstDataCount - 1)) begin
                    cnt_next   = '0;
                    state_next = S_IDLE;
                end else begin
                    ren      = 1'b1;
                    ptr_next = ptr_reg + PtrOne;
                    cnt_next = cnt_reg + CntOne;
                end
            end
            S_RECOVER: begin
                if (cnt_reg == CntW'(WriteRecoveryCycles - 1)) begin
                    cnt_next   = '0;
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt_reg + CntOne;
                end
            end
            default: state_next = S_INIT;
        endcase
    end

    // A reset edge must not commit the write beat presented on that same edge.
    assign mem_we = wen & ~rst;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            logic [7:0] lane_mem [Depth];
            logic [7:0] lane_q;

            always_ff @(posedge clk) begin
                if (mem_we && !data_mask[gi])
                    lane_mem[mem_addr] <= wr_data[gi*8 +: 8];
            end

            always_ff @(posedge clk) begin
                if (rst)
                    lane_q <= '0;
                else if (ren)
                    lane_q <= lane_mem[mem_addr];
            end

            assign rd_data[gi*8 +: 8] = lane_q;
        end

        if (DepthBitWidth + 3 <= 20) begin : g_addr_hi
            logic addr_unused;
            assign addr_unused = ^{addr[20:DepthBitWidth+3], addr[2:0]};
        end else begin : g_addr_lo
            logic addr_unused;
            assign addr_unused = ^addr[2:0];
        end
    endgenerate

    assign init_calib     = init_calib_reg;
    assign rd_data_valid  = rd_data_valid_reg;
    assign busy           = (state_reg != S_IDLE);
    assign protocol_error = protocol_error_reg;

endmodule
